// File: rtl/hazard_control.sv
// Load-use and multdiv interlock beside the DX/XM latches.
// Optional forced multdiv completion: define HAZARD_TIMEOUT_EN.
module hazard_control #(
    parameter int TIMEOUT = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] IR_D,
    input  logic [31:0] IR_X,
    input  logic        md_ready,
    input  logic        md_error,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic        stall_FD,
    output logic        stall_DX,
    output logic        nop_DX,
    output logic        nop_XM,
    output logic        md_busy,
    output logic        md_done,
    output logic        md_exception
);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_BEX   = 5'b10110;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;
    localparam logic [4:0] REG_ST   = 5'd30;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t state, state_n;

    logic [4:0] op_d, rd_d, rs_d, rt_d;
    logic [4:0] op_x, rd_x, alu_x;

    assign op_d  = IR_D[31:27];
    assign rd_d  = IR_D[26:22];
    assign rs_d  = IR_D[21:17];
    assign rt_d  = IR_D[16:12];
    assign op_x  = IR_X[31:27];
    assign rd_x  = IR_X[26:22];
    assign alu_x = IR_X[6:2];

    logic unused_bits;
    assign unused_bits = ^{IR_D[11:0], IR_X[21:7], IR_X[1:0]};

    logic x_mul, x_div, x_lw;

    assign x_mul = (op_x == OP_RTYPE) && (alu_x == ALU_MUL);
    assign x_div = (op_x == OP_RTYPE) && (alu_x == ALU_DIV);
    assign x_lw  = (op_x == OP_LW);

    logic       d_rtype, d_ri, d_sw, d_br, d_jr, d_bex;
    logic       sa_v, sb_v;
    logic [4:0] sa, sb;

    assign d_rtype = (op_d == OP_RTYPE);
    assign d_ri    = (op_d == OP_ADDI) || (op_d == OP_LW);
    assign d_sw    = (op_d == OP_SW);
    assign d_br    = (op_d == OP_BNE) || (op_d == OP_BLT);
    assign d_jr    = (op_d == OP_JR);
    assign d_bex   = (op_d == OP_BEX);

    always_comb begin
        sa_v = 1'b0;
        sb_v = 1'b0;
        sa   = '0;
        sb   = '0;
        unique case (1'b1)
            d_rtype: begin
                sa_v = 1'b1; sa = rs_d;
                sb_v = 1'b1; sb = rt_d;
            end
            d_ri: begin
                sa_v = 1'b1; sa = rs_d;
            end
            d_sw, d_br: begin
                sa_v = 1'b1; sa = rs_d;
                sb_v = 1'b1; sb = rd_d;
            end
            d_jr: begin
                sa_v = 1'b1; sa = rd_d;
            end
            d_bex: begin
                sa_v = 1'b1; sa = REG_ST;
            end
            default: ;
        endcase
    end

    // rd_x != 0 keeps r0 sources from ever matching
    logic lu_hit;

    assign lu_hit = x_lw && (rd_x != 5'd0) &&
                    ((sa_v && (sa == rd_x)) ||
                     (sb_v && (sb == rd_x)));

    logic tmo;

`ifdef HAZARD_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt, cnt_n;

    assign tmo = (state == WAIT) && !md_ready && (cnt == LAST);

    always_comb begin
        cnt_n = '0;
        if ((state == WAIT) && !md_ready && !tmo)
            cnt_n = cnt + CW'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cnt <= '0;
        else        cnt <= cnt_n;
    end
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_n      = state;
        ctrl_MULT    = 1'b0;
        ctrl_DIV     = 1'b0;
        stall_FD     = 1'b0;
        stall_DX     = 1'b0;
        nop_DX       = 1'b0;
        nop_XM       = 1'b0;
        md_busy      = 1'b0;
        md_done      = 1'b0;
        md_exception = 1'b0;
        if (reset) begin
            unique case (state)
                IDLE: begin
                    if (x_mul || x_div) begin
                        ctrl_MULT = x_mul;
                        ctrl_DIV  = x_div;
                        stall_FD  = 1'b1;
                        stall_DX  = 1'b1;
                        nop_XM    = 1'b1;
                        state_n   = WAIT;
                    end else if (lu_hit) begin
                        stall_FD = 1'b1;
                        nop_DX   = 1'b1;
                    end
                end
                WAIT: begin
                    if (md_ready) begin
                        md_done      = 1'b1;
                        md_exception = md_error;
                        state_n      = IDLE;
                    end else if (tmo) begin
                        md_done      = 1'b1;
                        md_exception = 1'b1;
                        state_n      = IDLE;
                    end else begin
                        stall_FD = 1'b1;
                        stall_DX = 1'b1;
                        nop_XM   = 1'b1;
                        md_busy  = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

endmodule

// File: tb/tb_hazard_control.sv
// Randomised bench for hazard_control with a rule-level reference model.
module tb_hazard_control;

    localparam int TMO = 40;
`ifdef HAZARD_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] IR_D, IR_X;
    logic        md_ready, md_error;
    logic        ctrl_MULT, ctrl_DIV, stall_FD, stall_DX;
    logic        nop_DX, nop_XM, md_busy, md_done, md_exception;
    logic [8:0]  outs;

    hazard_control #(.TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset), .IR_D(IR_D), .IR_X(IR_X),
        .md_ready(md_ready), .md_error(md_error),
        .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .stall_FD(stall_FD), .stall_DX(stall_DX),
        .nop_DX(nop_DX), .nop_XM(nop_XM), .md_busy(md_busy),
        .md_done(md_done), .md_exception(md_exception)
    );

    assign outs = {ctrl_MULT, ctrl_DIV, stall_FD, stall_DX, nop_DX,
                   nop_XM, md_busy, md_done, md_exception};

    always #5 clock = ~clock;

    // order: MULT DIV sFD sDX nDX nXM busy done exc
    localparam logic [8:0] O_NONE = 9'b000000000;
    localparam logic [8:0] O_SMUL = 9'b101101000;
    localparam logic [8:0] O_SDIV = 9'b011101000;
    localparam logic [8:0] O_WAIT = 9'b001101100;
    localparam logic [8:0] O_DONE = 9'b000000010;
    localparam logic [8:0] O_DEXC = 9'b000000011;
    localparam logic [8:0] O_LU   = 9'b001010000;

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;

    function automatic logic [31:0] rtype(logic [4:0] rd, logic [4:0] rs,
                                          logic [4:0] rt, logic [4:0] alu);
        return {5'b00000, rd, rs, rt, 5'd0, alu, 2'b00};
    endfunction

    function automatic logic [31:0] itype(logic [4:0] op, logic [4:0] rd,
                                          logic [4:0] rs, logic [16:0] imm);
        return {op, rd, rs, imm};
    endfunction

    function automatic bit reads(logic [31:0] d, logic [4:0] r);
        logic [4:0] op, rd, rs, rt;
        op = d[31:27]; rd = d[26:22]; rs = d[21:17]; rt = d[16:12];
        case (op)
            5'b00000:          return (r == rs) || (r == rt);
            5'b00101, 5'b01000: return r == rs;
            5'b00111:          return (r == rs) || (r == rd);
            5'b00010, 5'b00110: return (r == rd) || (r == rs);
            5'b00100:          return r == rd;
            5'b10110:          return r == 5'd30;
            default:           return 1'b0;
        endcase
    endfunction

    function automatic bit is_md(logic [31:0] x, logic [4:0] alu);
        return (x[31:27] == 5'b00000) && (x[6:2] == alu);
    endfunction

    // reference model: is an operation outstanding, and how long it has waited
    bit pending = 1'b0;
    int waited = 0;

    initial forever begin
        logic [8:0] exp;
        @(negedge clock);
        exp = O_NONE;
        if (reset !== 1'b1) begin
            pending = 1'b0;
            waited  = 0;
        end else if (pending) begin
            if (md_ready) begin
                exp = md_error ? O_DEXC : O_DONE;
                pending = 1'b0;
            end else if (TMO_EN && waited == TMO - 1) begin
                exp = O_DEXC;
                pending = 1'b0;
            end else begin
                exp = O_WAIT;
                waited++;
            end
        end else if (is_md(IR_X, 5'b00110)) begin
            exp = O_SMUL;
            pending = 1'b1;
            waited  = 0;
        end else if (is_md(IR_X, 5'b00111)) begin
            exp = O_SDIV;
            pending = 1'b1;
            waited  = 0;
        end else if (IR_X[31:27] == 5'b01000 && IR_X[26:22] != 5'd0 &&
                     reads(IR_D, IR_X[26:22])) begin
            exp = O_LU;
        end
        vectors++;
        if (outs !== exp) begin
            miscompares++;
            $display("FAIL model cycle %0d: outputs got %b want %b",
                     cycle, outs, exp);
        end
        cycle++;
    end

    task automatic chk(string nm, logic [8:0] got, logic [8:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %b want %b", nm, got, want);
        end
    endtask

    task automatic cyc(logic r, logic [31:0] x, logic [31:0] d,
                       logic rdy, logic err);
        @(posedge clock);
        #1;
        reset = r; IR_X = x; IR_D = d; md_ready = rdy; md_error = err;
        @(negedge clock);
        #1;
    endtask

    function automatic logic [4:0] pick_reg();
        if ($urandom_range(0, 9) == 0) return 5'd30;
        return 5'($urandom_range(0, 7));
    endfunction

    logic [31:0] NOP, ADD, MUL, DIV, LW5, LW0, LW9, LW4, SW4, BNE4, ADDI4;

    initial begin
        NOP   = 32'd0;
        ADD   = rtype(5'd7, 5'd5, 5'd3, 5'b00000);
        MUL   = rtype(5'd3, 5'd1, 5'd2, 5'b00110);
        DIV   = rtype(5'd6, 5'd4, 5'd0, 5'b00111);
        LW5   = itype(5'b01000, 5'd5, 5'd2, 17'd0);
        LW0   = itype(5'b01000, 5'd0, 5'd2, 17'd0);
        LW9   = itype(5'b01000, 5'd9, 5'd2, 17'd0);
        LW4   = itype(5'b01000, 5'd4, 5'd2, 17'd0);
        SW4   = itype(5'b00111, 5'd4, 5'd1, 17'd0);
        BNE4  = itype(5'b00010, 5'd4, 5'd1, 17'd8);
        ADDI4 = itype(5'b00101, 5'd4, 5'd1, 17'd1);

        reset = 1'b0; IR_X = MUL; IR_D = ADD;
        md_ready = 1'b1; md_error = 1'b1;

        cyc(0, MUL, ADD, 1, 1); chk("reset_low", outs, O_NONE);
        cyc(1, NOP, ADD, 0, 0); chk("post_reset", outs, O_NONE);

        cyc(1, LW5, ADD, 0, 0); chk("lu_add", outs, O_LU);
        cyc(1, NOP, ADD, 0, 0); chk("lu_bubble", outs, O_NONE);
        cyc(1, LW0, ADD, 0, 0); chk("lw_r0", outs, O_NONE);
        cyc(1, LW9, ADD, 0, 0); chk("lw_r9", outs, O_NONE);
        cyc(1, LW4, SW4, 0, 0); chk("lu_sw", outs, O_LU);
        cyc(1, LW4, BNE4, 0, 0); chk("lu_bne", outs, O_LU);
        cyc(1, LW4, ADDI4, 0, 0); chk("addi_rd", outs, O_NONE);
        cyc(1, NOP, ADD, 1, 1); chk("idle_ready", outs, O_NONE);

        cyc(1, MUL, ADD, 0, 0); chk("mul_start", outs, O_SMUL);
        for (int i = 1; i <= 16; i++) begin
            cyc(1, MUL, ADD, 0, 0);
            if (i == 1)  chk("mul_wait1", outs, O_WAIT);
            if (i == 16) chk("mul_wait16", outs, O_WAIT);
        end
        cyc(1, MUL, ADD, 1, 0); chk("mul_done", outs, O_DONE);
        cyc(1, DIV, ADD, 0, 0); chk("div_start", outs, O_SDIV);
        for (int i = 19; i <= 32; i++) cyc(1, DIV, ADD, 0, 0);
        cyc(1, DIV, ADD, 1, 1); chk("div_exc", outs, O_DEXC);
        cyc(1, NOP, ADD, 0, 1); chk("exc_once", outs, O_NONE);

        cyc(1, MUL, ADD, 0, 0);
        for (int i = 1; i <= 4; i++) cyc(1, MUL, ADD, 0, 0);
        cyc(0, MUL, ADD, 0, 0); chk("rst_wait", outs, O_NONE);
        cyc(1, NOP, ADD, 0, 0); chk("rst_release", outs, O_NONE);
        cyc(1, MUL, ADD, 0, 0); chk("rst_idle", outs, O_SMUL);
        cyc(1, NOP, ADD, 1, 0); chk("rst_done", outs, O_DONE);

        cyc(1, MUL, ADD, 0, 0);
        for (int w = 0; w <= 38; w++) cyc(1, MUL, ADD, 0, 0);
        cyc(1, NOP, ADD, 0, 0);
        if (TMO_EN) begin
            chk("tmo_force", outs, O_DEXC);
        end else begin
            chk("no_tmo", outs, O_WAIT);
            cyc(1, NOP, ADD, 1, 0); chk("no_tmo_done", outs, O_DONE);
        end

        for (int k = 0; k < 3000; k++) begin
            logic [31:0] x, d;
            logic [4:0] ops [8];
            int s;
            ops = '{5'b00000, 5'b00101, 5'b01000, 5'b00111,
                    5'b00010, 5'b00110, 5'b00100, 5'b10110};
            s = $urandom_range(0, 9);
            if (s == 0)
                x = rtype(pick_reg(), pick_reg(), pick_reg(), 5'b00110);
            else if (s == 1)
                x = rtype(pick_reg(), pick_reg(), pick_reg(), 5'b00111);
            else if (s <= 5)
                x = itype(5'b01000, pick_reg(), pick_reg(), 17'($urandom));
            else if (s <= 7)
                x = rtype(pick_reg(), pick_reg(), pick_reg(),
                          5'($urandom_range(0, 5)));
            else
                x = $urandom;
            if ($urandom_range(0, 9) == 0)
                d = $urandom;
            else
                d = itype(ops[$urandom_range(0, 7)], pick_reg(), pick_reg(),
                          {pick_reg(), 12'($urandom)});
            cyc(($urandom_range(0, 199) != 0), x, d,
                ($urandom_range(0, (k < 1500) ? 9 : 45) == 0),
                1'($urandom_range(0, 1)));
        end

        cyc(1, NOP, NOP, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
